// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative signed restoring divider, one quotient bit per clock.
// Optional zero-operand bypass: define SEQ_DIVIDER_EARLY_OUT_EN.

module ripple_carry_adder #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);

  logic [W:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[W];

endmodule

module seq_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [N-1:0]  ONE     = N'(1);
  localparam logic [CW-1:0] CNT_TOP = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    CALC,
    FIX
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]  dvd_q;
  logic [N-1:0]  dvs_q;
  logic [N:0]    dvs_mag_q;
  logic [N-1:0]  dq_q;
  logic [N-1:0]  prem_q;
  logic [CW-1:0] cnt_q;
  logic          sign_q_q;
  logic          sign_r_q;

  logic [N-1:0]  dvd_abs;
  logic [N-1:0]  dvs_abs;
  logic [N:0]    shifted;
  logic [N:0]    diff;
  logic          no_borrow;
  logic          unused_diff_msb;

  function automatic logic [N-1:0] negate(input logic [N-1:0] x);
    return ~x + ONE;
  endfunction

  // Magnitudes fit N unsigned bits even for the most-negative operand.
  assign dvd_abs = dvd_q[N-1] ? negate(dvd_q) : dvd_q;
  assign dvs_abs = dvs_q[N-1] ? negate(dvs_q) : dvs_q;

  // Partial remainder stays below |divisor|, so N bits plus the incoming bit suffice.
  assign shifted = {prem_q, dq_q[N-1]};

  ripple_carry_adder #(
    .W(N + 1)
  ) u_trial_sub (
    .a    (shifted),
    .b    (~dvs_mag_q),
    .c_in (1'b1),
    .sum  (diff),
    .c_out(no_borrow)
  );

  assign unused_diff_msb = diff[N];

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  logic early_out;
  logic [N-1:0] in_dvd_abs;

  assign early_out  = (dividend == '0) || (divisor == '0);
  assign in_dvd_abs = dividend[N-1] ? negate(dividend) : dividend;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
          state_d = early_out ? FIX : PREP;
`else
          state_d = PREP;
`endif
        end
      end
      PREP:    state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      dvs_mag_q   <= '0;
      dq_q        <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q       <= dividend;
            dvs_q       <= divisor;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
            if (early_out) begin
              dq_q     <= (divisor == '0) ? '1 : '0;
              prem_q   <= in_dvd_abs;
              sign_q_q <= dividend[N-1] ^ divisor[N-1];
              sign_r_q <= dividend[N-1];
            end
`endif
          end
        end
        PREP: begin
          dvs_mag_q <= {1'b0, dvs_abs};
          dq_q      <= dvd_abs;
          prem_q    <= '0;
          sign_q_q  <= dvd_q[N-1] ^ dvs_q[N-1];
          sign_r_q  <= dvd_q[N-1];
          cnt_q     <= CNT_TOP;
        end
        CALC: begin
          // dq_q shifts dividend bits out at the top and quotient bits in at the bottom.
          dq_q   <= {dq_q[N-2:0], no_borrow};
          prem_q <= no_borrow ? diff[N-1:0] : shifted[N-1:0];
          cnt_q  <= cnt_q - CNT_ONE;
        end
        FIX: begin
          if (dvs_q == '0) begin
            quotient  <= '1;
            remainder <= dvd_q;
          end else begin
            quotient  <= sign_q_q ? negate(dq_q) : dq_q;
            remainder <= sign_r_q ? negate(prem_q) : prem_q;
          end
          div_by_zero <= (dvs_q == '0);
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider (N=4) against an arithmetic model.

module tb_seq_divider;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int n_checks = 0;
  int n_pass = 0;

  seq_divider #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [N-1:0] ref_q(input logic [N-1:0] a, input logic [N-1:0] b);
    int ai, bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) return '1;
    return N'(ai / bi);
  endfunction

  function automatic logic [N-1:0] ref_r(input logic [N-1:0] a, input logic [N-1:0] b);
    int ai, bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) return a;
    return N'(ai % bi);
  endfunction

  // Cycles from the accepting edge to the edge that raises done.
  function automatic int ref_lat(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    if (a == '0 || b == '0) return 1;
`endif
    return N + 2;
  endfunction

  logic         m_busy = 1'b0;
  int           m_left = 0;
  logic [N-1:0] p_q = '0, p_r = '0;
  logic         p_dbz = 1'b0;
  logic [N-1:0] m_q = '0, m_r = '0;
  logic         m_dbz = 1'b0;
  logic         m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_left <= 0;
      m_q    <= '0;
      m_r    <= '0;
      m_dbz  <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_q    <= p_q;
          m_r    <= p_r;
          m_dbz  <= p_dbz;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= ref_lat(dividend, divisor);
        p_q    <= ref_q(dividend, divisor);
        p_r    <= ref_r(dividend, divisor);
        p_dbz  <= (divisor == '0);
        m_dbz  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_done", 32'(done), 32'(m_done));
    check("cmp_busy", 32'(busy), 32'(m_busy));
    check("cmp_dbz", 32'(div_by_zero), 32'(m_dbz));
    check("cmp_quotient", 32'(quotient), 32'(m_q));
    check("cmp_remainder", 32'(remainder), 32'(m_r));
  end

  // Caller sits at a negedge; returns at the negedge right after the accepting edge.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
  endtask

  task automatic wait_check(input int j0, input int lat, input logic [N-1:0] eq,
                            input logic [N-1:0] er, input logic edbz, input string name);
    int j;
    bit got;
    j = j0;
    got = 0;
    while (!got && j < 40) begin
      if (done) got = 1;
      else begin
        @(negedge clk);
        j++;
      end
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    check({name, "_latency"}, 32'(j), 32'(lat));
    check({name, "_q"}, 32'(quotient), 32'(eq));
    check({name, "_r"}, 32'(remainder), 32'(er));
    check({name, "_dbz"}, 32'(div_by_zero), 32'(edbz));
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] eq,
                        input logic [N-1:0] er, input logic edbz, input string name);
    launch(a, b);
    wait_check(0, ref_lat(a, b), eq, er, edbz, name);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("reset_q", 32'(quotient), 32'd0);
    check("reset_r", 32'(remainder), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'd7, 4'd2, 4'h3, 4'h1, 1'b0, "p7_d2");
    run_op(4'h9, 4'd2, 4'hD, 4'hF, 1'b0, "m7_d2");
    run_op(4'd7, 4'hE, 4'hD, 4'h1, 1'b0, "p7_dm2");
    run_op(4'h9, 4'hE, 4'h3, 4'hF, 1'b0, "m7_dm2");
    run_op(4'h8, 4'hF, 4'h8, 4'h0, 1'b0, "m8_dm1");
    run_op(4'h8, 4'h1, 4'h8, 4'h0, 1'b0, "m8_d1");
    run_op(4'd5, 4'd0, 4'hF, 4'h5, 1'b1, "p5_d0");
    run_op(4'hB, 4'd0, 4'hF, 4'hB, 1'b1, "m5_d0");
    run_op(4'd0, 4'd3, 4'h0, 4'h0, 1'b0, "z_d3");

    // A start pulse while busy is dropped.
    launch(4'd6, 4'd3);
    @(negedge clk);
    @(negedge clk);
    dividend = 4'd1;
    divisor  = 4'd1;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_check(3, N + 2, 4'h2, 4'h0, 1'b0, "p6_d3_ignore");

    // Start raised in the done cycle is accepted immediately.
    run_op(4'hA, 4'd4, 4'hF, 4'hE, 1'b0, "m6_d4_b2b");

    // Asynchronous reset mid-operation clears outputs without waiting for a clock.
    launch(4'd7, 4'd2);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_q", 32'(quotient), 32'd0);
    check("midrst_r", 32'(remainder), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(4'd5, 4'd2, 4'h2, 4'h1, 1'b0, "p5_d2_after_rst");

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
